// File: rtl/mix_word_sched.sv
// mix_word_sched: three commit/rewind word FIFOs drained by a round-robin, packet-atomic arbiter.
module mix_word_sched #(
    parameter int FIFO_AW  = 7,
    parameter int HEAD_LEN = 4,
    parameter int BODY_LEN = 51,
    parameter int DDR_LEN  = 51
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        head_din_en,
    input  logic [31:0] head_din,
    input  logic        head_sop,
    input  logic        body_din_en,
    input  logic [31:0] body_din,
    input  logic        body_sop,
    input  logic        ddr_din_en,
    input  logic [32:0] ddr_din,
    input  logic        out_ready,
    output logic        out_en,
    output logic [31:0] out_data,
    output logic        out_sop,
    output logic        out_eop,
    output logic [1:0]  out_src,
    output logic [2:0]  drop_pulse,
    output logic [2:0]  pkt_pending
);
    localparam int PW = FIFO_AW + 1;
    typedef enum logic {IDLE, SEND} state_t;
    state_t r_state, w_state_n;
    logic [2:0]       w_en, w_sop, w_drop, w_pend;
    logic [2:0][31:0] w_din, w_rdata;
    logic [1:0]       r_gnt, r_last, w_c0, w_c1, w_c2, w_pick;
    logic [7:0]       r_wcnt, w_glen;
    logic             w_pop, w_pop_last;
    logic             r_out_en, r_out_sop, r_out_eop;
    logic [31:0]      r_out_data;
    logic [1:0]       r_out_src;
    logic [2:0]       r_drop;
    assign w_en  = {ddr_din_en, body_din_en, head_din_en};
    assign w_sop = {ddr_din[32], body_sop, head_sop};
    assign w_din = {ddr_din[31:0], body_din, head_din};
    for (genvar g = 0; g < 3; g++) begin : g_src
        localparam int LEN = g == 0 ? HEAD_LEN : g == 1 ? BODY_LEN : DDR_LEN;
        logic [31:0]   r_mem [2**FIFO_AW];
        logic [PW-1:0] r_wr, r_cm, r_rd, w_base, w_addr, w_occ;
        logic [7:0]    r_wc, r_pc, w_wc_n;
        logic          r_act, w_trunc, w_room, w_start, w_wr, w_commit, w_rpop, w_rlast;
        // a sop inside an open packet rewinds first, so free space is judged after the rewind
        assign w_trunc  = w_en[g] & w_sop[g] & r_act;
        assign w_base   = w_trunc ? r_cm : r_wr;
        assign w_occ    = w_base - r_rd;
        assign w_room   = (PW+1)'(w_occ) + (PW+1)'(LEN) <= (PW+1)'(2**FIFO_AW);
        assign w_start  = w_en[g] & w_sop[g] & w_room;
        assign w_wr     = w_start | (w_en[g] & ~w_sop[g] & r_act);
        assign w_addr   = w_start ? w_base : r_wr;
        assign w_wc_n   = w_start ? 8'd1 : r_wc + 8'd1;
        assign w_commit = w_wr & (w_wc_n == 8'(LEN));
        assign w_rpop   = w_pop & (r_gnt == 2'(g));
        assign w_rlast  = w_pop_last & (r_gnt == 2'(g));
        assign w_drop[g]  = w_trunc | (w_en[g] & w_sop[g] & ~w_room);
        assign w_pend[g]  = |r_pc;
        assign w_rdata[g] = r_mem[r_rd[FIFO_AW-1:0]];
        always_ff @(posedge clk)
            if (w_wr) r_mem[w_addr[FIFO_AW-1:0]] <= w_din[g];
        always_ff @(posedge clk) begin
            if (rst) begin
                r_wr  <= '0;
                r_cm  <= '0;
                r_rd  <= '0;
                r_wc  <= '0;
                r_pc  <= '0;
                r_act <= 1'b0;
            end else begin
                r_wr  <= w_wr ? w_addr + PW'(1) : w_base;
                r_cm  <= w_commit ? w_addr + PW'(1) : r_cm;
                r_rd  <= r_rd + PW'(w_rpop);
                r_wc  <= w_wr ? w_wc_n : r_wc;
                r_act <= w_wr ? ~w_commit : (w_en[g] & w_sop[g]) ? 1'b0 : r_act;
                r_pc  <= r_pc + 8'(w_commit) - 8'(w_rlast);
            end
        end
    end
    assign w_c0   = r_last == 2'd2 ? 2'd0 : r_last + 2'd1;
    assign w_c1   = w_c0 == 2'd2 ? 2'd0 : w_c0 + 2'd1;
    assign w_c2   = w_c1 == 2'd2 ? 2'd0 : w_c1 + 2'd1;
    assign w_pick = w_pend[w_c0] ? w_c0 : w_pend[w_c1] ? w_c1 : w_c2;
    assign w_glen = r_gnt == 2'd0 ? 8'(HEAD_LEN) : r_gnt == 2'd1 ? 8'(BODY_LEN) : 8'(DDR_LEN);
    assign w_pop      = (r_state == SEND) & out_ready;
    assign w_pop_last = w_pop & (r_wcnt == w_glen - 8'd1);
    always_comb begin
        w_state_n = r_state == IDLE ? (|w_pend ? SEND : IDLE) : (w_pop_last ? IDLE : SEND);
    end
    always_ff @(posedge clk)
        r_state <= rst ? IDLE : w_state_n;
    always_ff @(posedge clk) begin
        if (rst) begin
            r_gnt      <= 2'd0;
            r_last     <= 2'd2;
            r_wcnt     <= '0;
            r_out_en   <= 1'b0;
            r_out_data <= '0;
            r_out_sop  <= 1'b0;
            r_out_eop  <= 1'b0;
            r_out_src  <= 2'd0;
            r_drop     <= '0;
        end else begin
            r_gnt      <= r_state == IDLE ? w_pick : r_gnt;
            r_wcnt     <= r_state == IDLE ? 8'd0 : r_wcnt + 8'(w_pop);
            r_last     <= w_pop_last ? r_gnt : r_last;
            r_out_en   <= w_pop;
            r_out_data <= w_pop ? w_rdata[r_gnt] : 32'd0;
            r_out_sop  <= w_pop & (r_wcnt == 8'd0);
            r_out_eop  <= w_pop_last;
            r_out_src  <= w_pop ? r_gnt : r_out_src;
            r_drop     <= w_drop;
        end
    end
    assign out_en      = r_out_en;
    assign out_data    = r_out_data;
    assign out_sop     = r_out_sop;
    assign out_eop     = r_out_eop;
    assign out_src     = r_out_src;
    assign drop_pulse  = r_drop;
    assign pkt_pending = w_pend;
endmodule

// File: tb/tb_mix_word_sched.sv
// tb_mix_word_sched: random and directed traffic scored against a per-source packet queue model.
module tb_mix_word_sched;
    logic        clk = 0, rst = 1;
    logic        head_din_en = 0, head_sop = 0, body_din_en = 0, body_sop = 0, ddr_din_en = 0;
    logic [31:0] head_din = 0, body_din = 0;
    logic [32:0] ddr_din = 0;
    logic        out_ready = 0;
    logic        out_en, out_sop, out_eop;
    logic [31:0] out_data;
    logic [1:0]  out_src;
    logic [2:0]  drop_pulse, pkt_pending;

    mix_word_sched dut (
        .clk(clk), .rst(rst),
        .head_din_en(head_din_en), .head_din(head_din), .head_sop(head_sop),
        .body_din_en(body_din_en), .body_din(body_din), .body_sop(body_sop),
        .ddr_din_en(ddr_din_en), .ddr_din(ddr_din),
        .out_ready(out_ready), .out_en(out_en), .out_data(out_data),
        .out_sop(out_sop), .out_eop(out_eop), .out_src(out_src),
        .drop_pulse(drop_pulse), .pkt_pending(pkt_pending)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_pass = 0, cyc_n = 0, ph = 0, rmode = 0;
    logic [31:0] expq [3][$];
    logic [31:0] cur [3][$];
    bit inpkt [3];
    int dexp [3], dobs [3], ncommit [3];
    bit mon_on = 0, in_out = 0, prev_rdy = 0;
    int pos = 0, cur_src = 0;
    int ord_q [$], sopc_q [$], eopc_q [$];

    always @(posedge clk) cyc_n <= cyc_n + 1;

    function automatic int plen(input int s);
        return s == 0 ? 4 : 51;
    endfunction

    function automatic int ord_code();
        int c;
        c = 0;
        foreach (ord_q[i]) c = c * 4 + ord_q[i];
        return c;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        else n_pass++;
    endtask

    // whole-packet model: a packet becomes visible only once all its words have arrived
    task automatic model_in(input int s, input bit sop, input logic [31:0] d);
        bit dr;
        dr = 0;
        if (sop) begin
            if (inpkt[s]) begin
                dr = 1;
                cur[s].delete();
                inpkt[s] = 0;
            end
            if (128 - expq[s].size() >= plen(s)) begin
                inpkt[s] = 1;
                cur[s].push_back(d);
            end else dr = 1;
        end else if (inpkt[s]) cur[s].push_back(d);
        if (inpkt[s] && cur[s].size() == plen(s)) begin
            for (int i = 0; i < cur[s].size(); i++) expq[s].push_back(cur[s][i]);
            cur[s].delete();
            inpkt[s] = 0;
            ncommit[s]++;
        end
        if (dr) dexp[s]++;
    endtask

    task automatic put(input int s, input bit en, input bit sop, input logic [31:0] d);
        case (s)
            0: begin head_din_en = en; head_sop = sop; head_din = d; end
            1: begin body_din_en = en; body_sop = sop; body_din = d; end
            default: begin ddr_din_en = en; ddr_din = {sop, d}; end
        endcase
        if (en) model_in(s, sop, d);
        @(posedge clk);
        #1;
        case (s)
            0: head_din_en = 0;
            1: body_din_en = 0;
            default: ddr_din_en = 0;
        endcase
    endtask

    task automatic send_pkt(input int s, input int n);
        for (int i = 0; i < n; i++) put(s, 1, i == 0, $urandom);
    endtask

    task automatic send_aligned(input int s);
        repeat (51 - plen(s)) put(s, 0, 0, 0);
        send_pkt(s, plen(s));
    endtask

    task automatic flush();
        for (int s = 0; s < 3; s++) begin
            expq[s].delete();
            cur[s].delete();
            inpkt[s] = 0;
            dexp[s] = 0;
            dobs[s] = 0;
            ncommit[s] = 0;
        end
        in_out = 0;
        pos = 0;
        ord_q.delete();
        sopc_q.delete();
        eopc_q.delete();
    endtask

    task automatic do_reset();
        rst = 1;
        repeat (2) @(posedge clk);
        #1;
        flush();
        rst = 0;
    endtask

    task automatic wait_drain(input int budget);
        int k;
        k = 0;
        while ((expq[0].size() + expq[1].size() + expq[2].size() != 0 || in_out) && k < budget) begin
            @(posedge clk);
            #1;
            k++;
        end
        chk("drain_timeout", k >= budget, 0);
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic rnd_src(input int s, input int npk);
        int k, n;
        for (int p = 0; p < npk; p++) begin
            k = 0;
            while (expq[s].size() > (s == 0 ? 8 : 51) && k < 5000) begin
                put(s, 0, 0, 0);
                k++;
            end
            n = (p < npk - 1 && $urandom_range(0, 4) == 0) ? $urandom_range(1, plen(s) - 1) : plen(s);
            for (int i = 0; i < n; i++) begin
                put(s, 1, i == 0, $urandom);
                if ($urandom_range(0, 3) == 0) put(s, 0, 0, 0);
            end
            if (n == plen(s) && $urandom_range(0, 2) == 0) put(s, 1, 0, $urandom);
            repeat ($urandom_range(0, 3)) put(s, 0, 0, 0);
        end
    endtask

    initial forever begin
        @(posedge clk);
        #1;
        if (rmode == 1) begin
            out_ready = (ph % 4 == 0) || (ph % 4 == 3);
            ph++;
        end else if (rmode == 2) out_ready = 1'($urandom_range(0, 1));
    end

    always @(negedge clk) begin
        int s;
        if (mon_on) begin
            for (int b = 0; b < 3; b++) if (drop_pulse[b]) dobs[b]++;
            if (out_en) begin
                s = int'(out_src);
                chk("ready_before_en", prev_rdy, 1);
                if (!in_out) begin
                    in_out = 1;
                    cur_src = s > 2 ? 2 : s;
                    pos = 0;
                    ord_q.push_back(s);
                    sopc_q.push_back(cyc_n);
                end
                chk("src_hold", out_src, cur_src);
                chk("sop", out_sop, pos == 0);
                chk("eop", out_eop, pos == plen(cur_src) - 1);
                chk("word_expected", expq[cur_src].size() != 0, 1);
                if (expq[cur_src].size() != 0) chk("data", out_data, expq[cur_src].pop_front());
                pos++;
                if (pos == plen(cur_src)) begin
                    in_out = 0;
                    eopc_q.push_back(cyc_n);
                end
            end else chk("idle_zero", {out_data, out_sop, out_eop}, 0);
            prev_rdy = out_ready;
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int t_last, k;
        do_reset();
        mon_on = 1;
        chk("rst_out_en", out_en, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_sop_eop_src", {out_sop, out_eop, out_src}, 0);
        chk("rst_drop", drop_pulse, 0);
        chk("rst_pending", pkt_pending, 0);

        // single DDR packet latency and framing
        out_ready = 1;
        send_pkt(2, 50);
        t_last = cyc_n;
        put(2, 1, 0, $urandom);
        wait_drain(400);
        chk("t1_pkts", ord_q.size(), 1);
        if (ord_q.size() == 1) begin
            chk("t1_src", ord_q[0], 2);
            chk("t1_first_cycle", sopc_q[0], t_last + 3);
            chk("t1_last_cycle", eopc_q[0], t_last + 53);
        end

        // simultaneous commit: round robin order
        do_reset();
        fork
            send_aligned(0);
            send_aligned(1);
            send_aligned(2);
        join
        wait_drain(600);
        chk("t2_order_hbd", ord_code(), 6);
        ord_q.delete();
        fork
            send_aligned(0);
            send_aligned(1);
        join
        wait_drain(600);
        chk("t2_order_hb", ord_code(), 1);

        // toggling ready
        do_reset();
        ph = 0;
        rmode = 1;
        send_pkt(1, 51);
        wait_drain(800);
        rmode = 0;
        out_ready = 1;
        chk("t3_pkts", ord_q.size(), 1);
        if (eopc_q.size() == 1) chk("t3_stretched", eopc_q[0] - sopc_q[0] > 50, 1);

        // truncated body packet
        do_reset();
        send_pkt(1, 20);
        send_pkt(1, 51);
        wait_drain(800);
        chk("t4_drop", dobs[1], 1);
        chk("t4_pkts", ord_q.size(), 1);

        // overflow with ready low
        do_reset();
        out_ready = 0;
        repeat (3) send_pkt(2, 51);
        repeat (4) @(posedge clk);
        #1;
        chk("t5_pending", pkt_pending, 3'b100);
        chk("t5_drop", dobs[2], 1);
        out_ready = 1;
        wait_drain(800);
        chk("t5_pkts", ord_q.size(), 2);
        chk("t5_pending_after", pkt_pending, 0);

        // reset mid-packet
        do_reset();
        send_pkt(2, 51);
        k = 0;
        while (!(in_out && pos >= 25) && k < 300) begin
            @(posedge clk);
            #1;
            k++;
        end
        chk("t6_reach_word25", k >= 300, 0);
        rst = 1;
        @(posedge clk);
        #1;
        flush();
        chk("t6_en_after_rst", out_en, 0);
        chk("t6_pending_after_rst", pkt_pending, 0);
        rst = 0;
        send_pkt(0, 4);
        wait_drain(400);
        chk("t6_order", ord_code(), 0);
        chk("t6_pkts", ord_q.size(), 1);

        // random concurrent traffic
        do_reset();
        rmode = 2;
        fork
            rnd_src(0, 20);
            rnd_src(1, 10);
            rnd_src(2, 10);
        join
        wait_drain(30000);
        rmode = 0;
        out_ready = 1;
        for (int s = 0; s < 3; s++) chk($sformatf("rand_drops_%0d", s), dobs[s], dexp[s]);
        chk("rand_pkts", ord_q.size(), ncommit[0] + ncommit[1] + ncommit[2]);
        chk("rand_pending", pkt_pending, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
